// File: rtl/pipe_shifter_if.sv
// Elastic operand/result bus for pipe_shifter.
// The master drives operations in and accepts results; the slave is the shifter.
interface pipe_shifter_if #(
    parameter int WIDTH = 16
);
    localparam int CNTW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] In;
    logic [CNTW-1:0]  Cnt;
    logic [2:0]       Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic             Err;

    modport master (
        output in_valid, In, Cnt, Op, out_ready,
        input  in_ready, out_valid, Out, Err
    );

    modport slave (
        input  in_valid, In, Cnt, Op, out_ready,
        output in_ready, out_valid, Out, Err
    );
endinterface

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter/rotator with a valid/ready elastic handshake.
// The log2(WIDTH) shift levels are spread evenly over PIPE register stages;
// each stage carries its partially shifted data plus the count, op and the
// entry sign bit forward so later stages can finish the job.
module pipe_shifter #(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_shifter_if.slave    bus
);
    localparam int CNTW = $clog2(WIDTH);
    localparam int L    = (CNTW + PIPE - 1) / PIPE;

    localparam logic [2:0] OP_ROTL = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_ROTR = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;

    // Stage registers
    logic [WIDTH-1:0] data_q [PIPE];
    logic [WIDTH-1:0] data_d [PIPE];
    logic [CNTW-1:0]  cnt_q  [PIPE];
    logic [CNTW-1:0]  cnt_d  [PIPE];
    logic [2:0]       op_q   [PIPE];
    logic [2:0]       op_d   [PIPE];
    logic [PIPE-1:0]  sign_q;
    logic [PIPE-1:0]  sign_d;
    logic [PIPE-1:0]  valid_q;
    logic [PIPE-1:0]  valid_d;

    // What each stage would capture if it loads this cycle
    logic [WIDTH-1:0] src_data [PIPE];
    logic [CNTW-1:0]  src_cnt  [PIPE];
    logic [2:0]       src_op   [PIPE];
    logic [PIPE-1:0]  src_sign;
    logic [PIPE-1:0]  src_valid;

    logic [PIPE-1:0]  load;

    // Last stage count/sign bits have no consumer beyond the pipeline end
    logic unused_tail;
    assign unused_tail = ^{cnt_q[PIPE-1], sign_q[PIPE-1]};

    // One shift level of fixed power-of-two amount for the given op
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int               amt,
        input logic [2:0]       op,
        input logic             sign
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_ROTL: r = (d << amt) | (d >> (WIDTH - amt));
            OP_SHL:  r = d << amt;
            OP_ROTR: r = (d >> amt) | (d << (WIDTH - amt));
            OP_SHR:  r = d >> amt;
            OP_SRA:  r = (d >> amt) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> amt));
            default: r = d;
        endcase
        return r;
    endfunction

    // Apply only the levels owned by stage s, gated by their count bits
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [CNTW-1:0]  cnt,
        input logic [2:0]       op,
        input logic             sign,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < CNTW; k++) begin
            if (k >= s * L && k < (s + 1) * L && cnt[k]) begin
                r = shift_level(r, 1 << k, op, sign);
            end
        end
        return r;
    endfunction

    // Load chain: a stage loads if empty or if its successor loads;
    // this makes in_ready combinational from out_ready
    always_comb begin
        logic ld;
        load = '0;
        ld   = !valid_q[PIPE-1] || bus.out_ready;
        load[PIPE-1] = ld;
        for (int i = PIPE - 2; i >= 0; i--) begin
            ld      = !valid_q[i] || ld;
            load[i] = ld;
        end
    end

    // Datapath and next-state: move items forward on load, drop on flush
    always_comb begin
        src_data[0]  = bus.In;
        src_cnt[0]   = bus.Cnt;
        src_op[0]    = bus.Op;
        src_sign[0]  = bus.In[WIDTH-1];
        src_valid[0] = bus.in_valid;
        for (int s = 1; s < PIPE; s++) begin
            src_data[s]  = data_q[s-1];
            src_cnt[s]   = cnt_q[s-1];
            src_op[s]    = op_q[s-1];
            src_sign[s]  = sign_q[s-1];
            src_valid[s] = valid_q[s-1];
        end

        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sign_d  = sign_q;
        valid_d = valid_q;

        for (int s = 0; s < PIPE; s++) begin
            if (load[s]) begin
                valid_d[s] = src_valid[s];
                if (src_valid[s]) begin
                    data_d[s] = stage_shift(src_data[s], src_cnt[s], src_op[s],
                                            src_sign[s], s);
                    cnt_d[s]  = src_cnt[s];
                    op_d[s]   = src_op[s];
                    sign_d[s] = src_sign[s];
                end
            end
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    // Stage registers with synchronous reset; reset wins over flush and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE; s++) begin
                data_q[s] <= '0;
                cnt_q[s]  <= '0;
                op_q[s]   <= '0;
            end
            sign_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_q[PIPE-1];
    assign bus.Out       = data_q[PIPE-1];
    assign bus.Err       = (op_q[PIPE-1] > OP_SRA);

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed self-checking bench for pipe_shifter: a 16-bit/2-stage instance
// for function, back-pressure, flush and reset, and a 32-bit/5-stage instance
// for wide shifts and latency.
module tb_pipe_shifter;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    pipe_shifter_if #(.WIDTH(16)) bus16 ();
    pipe_shifter_if #(.WIDTH(32)) bus32 ();

    pipe_shifter #(.WIDTH(16), .PIPE(2)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus16)
    );

    pipe_shifter #(.WIDTH(32), .PIPE(5)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0]  vec_op  [8];
    logic [15:0] vec_in  [8];
    logic [3:0]  vec_cnt [8];
    logic [15:0] exp_out [8];
    logic        exp_err [8];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [15:0] d, input logic [3:0] c);
        bus16.in_valid = v;
        bus16.Op       = op;
        bus16.In       = d;
        bus16.Cnt      = c;
    endtask

    task automatic applyStimulus32(input logic v, input logic [2:0] op,
                                   input logic [31:0] d, input logic [4:0] c);
        bus32.in_valid = v;
        bus32.Op       = op;
        bus32.In       = d;
        bus32.Cnt      = c;
    endtask

    // Back-to-back stream from the vector tables into an empty 2-stage pipe
    task automatic runStream(input int n);
        for (int i = 0; i <= n + 1; i++) begin
            if (i < n) applyStimulus(1'b1, vec_op[i], vec_in[i], vec_cnt[i]);
            else       applyStimulus(1'b0, 3'b000, 16'h0000, 4'h0);
            tick();
            if (i == 0 || i == n + 1) begin
                checkOutput($sformatf("stream idle valid %0d", i), bus16.out_valid, 64'd0);
            end else begin
                checkOutput($sformatf("stream valid %0d", i - 1), bus16.out_valid, 64'd1);
                checkOutput($sformatf("stream out %0d", i - 1), bus16.Out, exp_out[i-1]);
                checkOutput($sformatf("stream err %0d", i - 1), bus16.Err, exp_err[i-1]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 3'b000, 16'h0000, 4'h0);
        applyStimulus32(1'b0, 3'b000, 32'h0, 5'h0);
        bus16.out_ready = 1'b1;
        bus32.out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("reset out_valid", bus16.out_valid, 64'd0);
        checkOutput("reset Out", bus16.Out, 64'd0);
        checkOutput("reset Err", bus16.Err, 64'd0);
        checkOutput("reset in_ready", bus16.in_ready, 64'd1);
        checkOutput("reset Out32", bus32.Out, 64'd0);

        $display("[TB] legal op stream");
        vec_op[0] = 3'b000; vec_in[0] = 16'h8001; vec_cnt[0] = 4'd1;  exp_out[0] = 16'h0003; exp_err[0] = 1'b0;
        vec_op[1] = 3'b001; vec_in[1] = 16'h00FF; vec_cnt[1] = 4'd4;  exp_out[1] = 16'h0FF0; exp_err[1] = 1'b0;
        vec_op[2] = 3'b010; vec_in[2] = 16'h0001; vec_cnt[2] = 4'd1;  exp_out[2] = 16'h8000; exp_err[2] = 1'b0;
        vec_op[3] = 3'b011; vec_in[3] = 16'h8000; vec_cnt[3] = 4'd15; exp_out[3] = 16'h0001; exp_err[3] = 1'b0;
        vec_op[4] = 3'b100; vec_in[4] = 16'h8000; vec_cnt[4] = 4'd3;  exp_out[4] = 16'hF000; exp_err[4] = 1'b0;
        vec_op[5] = 3'b000; vec_in[5] = 16'h8001; vec_cnt[5] = 4'd15; exp_out[5] = 16'hC000; exp_err[5] = 1'b0;
        runStream(6);

        $display("[TB] zero count and reserved op");
        for (int i = 0; i < 5; i++) begin
            vec_op[i]  = 3'(i);
            vec_in[i]  = 16'hA5C3;
            vec_cnt[i] = 4'd0;
            exp_out[i] = 16'hA5C3;
            exp_err[i] = 1'b0;
        end
        vec_op[5] = 3'b110; vec_in[5] = 16'h1234; vec_cnt[5] = 4'd5; exp_out[5] = 16'h1234; exp_err[5] = 1'b1;
        runStream(6);

        $display("[TB] back-pressure");
        bus16.out_ready = 1'b0;
        applyStimulus(1'b1, 3'b000, 16'h0001, 4'd1);
        #1 checkOutput("bp in_ready A", bus16.in_ready, 64'd1);
        tick();
        applyStimulus(1'b1, 3'b001, 16'h0001, 4'd2);
        #1 checkOutput("bp in_ready B", bus16.in_ready, 64'd1);
        tick();
        checkOutput("bp first valid", bus16.out_valid, 64'd1);
        checkOutput("bp first Out", bus16.Out, 64'h0002);
        applyStimulus(1'b1, 3'b001, 16'h0001, 4'd3);
        for (int i = 0; i < 2; i++) begin
            #1 checkOutput($sformatf("bp full in_ready %0d", i), bus16.in_ready, 64'd0);
            tick();
            checkOutput($sformatf("bp hold valid %0d", i), bus16.out_valid, 64'd1);
            checkOutput($sformatf("bp hold Out %0d", i), bus16.Out, 64'h0002);
            checkOutput($sformatf("bp hold Err %0d", i), bus16.Err, 64'd0);
        end
        bus16.out_ready = 1'b1;
        #1 checkOutput("bp release in_ready", bus16.in_ready, 64'd1);
        tick();
        checkOutput("bp drain Out B", bus16.Out, 64'h0004);
        applyStimulus(1'b1, 3'b001, 16'h0001, 4'd4);
        tick();
        checkOutput("bp drain Out C", bus16.Out, 64'h0008);
        applyStimulus(1'b0, 3'b000, 16'h0000, 4'h0);
        tick();
        checkOutput("bp drain valid D", bus16.out_valid, 64'd1);
        checkOutput("bp drain Out D", bus16.Out, 64'h0010);
        tick();
        checkOutput("bp empty valid", bus16.out_valid, 64'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 3'b001, 16'h0001, 4'd5);
        tick();
        applyStimulus(1'b1, 3'b001, 16'h0003, 4'd2);
        tick();
        checkOutput("flush pre valid", bus16.out_valid, 64'd1);
        checkOutput("flush pre Out", bus16.Out, 64'h0020);
        applyStimulus(1'b1, 3'b011, 16'hFFFF, 4'd1);
        flush = 1'b1;
        #1 checkOutput("flush in_ready", bus16.in_ready, 64'd1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 3'b000, 16'h0000, 4'h0);
        checkOutput("flush valid", bus16.out_valid, 64'd0);
        applyStimulus(1'b1, 3'b010, 16'h0003, 4'd1);
        tick();
        checkOutput("flush fresh early", bus16.out_valid, 64'd0);
        applyStimulus(1'b0, 3'b000, 16'h0000, 4'h0);
        tick();
        checkOutput("flush fresh valid", bus16.out_valid, 64'd1);
        checkOutput("flush fresh Out", bus16.Out, 64'h8001);
        tick();
        checkOutput("flush fresh alone", bus16.out_valid, 64'd0);

        $display("[TB] reset mid-stream");
        bus16.out_ready = 1'b0;
        applyStimulus(1'b1, 3'b111, 16'h1234, 4'd2);
        tick();
        applyStimulus(1'b1, 3'b001, 16'h0001, 4'd1);
        tick();
        checkOutput("rst pre valid", bus16.out_valid, 64'd1);
        checkOutput("rst pre Err", bus16.Err, 64'd1);
        checkOutput("rst pre Out", bus16.Out, 64'h1234);
        bus16.out_ready = 1'b1;
        applyStimulus(1'b1, 3'b000, 16'h00F0, 4'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 3'b000, 16'h0000, 4'h0);
        bus16.out_ready = 1'b0;
        #1;
        checkOutput("rst valid", bus16.out_valid, 64'd0);
        checkOutput("rst Out", bus16.Out, 64'd0);
        checkOutput("rst Err", bus16.Err, 64'd0);
        checkOutput("rst in_ready", bus16.in_ready, 64'd1);
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("rst no stale %0d", i), bus16.out_valid, 64'd0);
        end

        $display("[TB] 32-bit five-stage");
        for (int i = 0; i <= 6; i++) begin
            if (i == 0)      applyStimulus32(1'b1, 3'b100, 32'h80000000, 5'd31);
            else if (i == 1) applyStimulus32(1'b1, 3'b010, 32'h00000001, 5'd31);
            else             applyStimulus32(1'b0, 3'b000, 32'h0, 5'd0);
            tick();
            if (i < 4 || i == 6) begin
                checkOutput($sformatf("w32 idle valid %0d", i), bus32.out_valid, 64'd0);
            end else if (i == 4) begin
                checkOutput("w32 sra valid", bus32.out_valid, 64'd1);
                checkOutput("w32 sra Out", bus32.Out, 64'hFFFFFFFF);
                checkOutput("w32 sra Err", bus32.Err, 64'd0);
            end else begin
                checkOutput("w32 rotr valid", bus32.out_valid, 64'd1);
                checkOutput("w32 rotr Out", bus32.Out, 64'h00000002);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
